// File: rtl/uart_rx_byte_if.sv
// Byte-level handshake between the UART receiver (master) and its consumer (slave).
// The receiver drives the byte and its valid flag; the consumer answers with a level ack.
interface uart_rx_byte_if;
  logic [7:0] UART_RX;
  logic       UART_RX_valid;
  logic       UART_RX_ack;

  modport master (
    output UART_RX,
    output UART_RX_valid,
    input  UART_RX_ack
  );

  modport slave (
    input  UART_RX,
    input  UART_RX_valid,
    output UART_RX_ack
  );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronises RX_SERIAL, assembles bytes LSB first, and hands
// each byte over through a one-entry holding register with a valid/ack handshake.
module uart_rx_byte #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           RX_SERIAL,
  uart_rx_byte_if.master rx_if,
  output logic           FRAME_ERR,
  output logic           OVERRUN,
  output logic           RX_BUSY
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             pending_q, pending_d;
  logic             ack_wait_q, ack_wait_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic rx_s;
  logic cnt_zero_s;
  logic load_half_s, load_bit_s, dec_s, clr_idx_s, shift_en_s;
  logic byte_done_s, frame_err_s, consume_s;

  assign rx_s       = sync_q[1];
  assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
  assign consume_s  = valid_q & rx_if.UART_RX_ack;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
        else       state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_zero_s) begin
          if (!rx_s) state_d = S_DATA;
          else       state_d = S_IDLE;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_zero_s && (bit_idx_q == 3'd7)) state_d = S_STOP;
        else                                   state_d = S_DATA;
      end
      S_STOP: begin
        if (cnt_zero_s) begin
          if (rx_s) state_d = S_IDLE;
          else      state_d = S_BREAK;
        end else begin
          state_d = S_STOP;
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
        else      state_d = S_BREAK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode: counter control, bit capture and end-of-frame strobes
  always_comb begin
    load_half_s = 1'b0;
    load_bit_s  = 1'b0;
    dec_s       = 1'b0;
    clr_idx_s   = 1'b0;
    shift_en_s  = 1'b0;
    byte_done_s = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) load_half_s = 1'b1;
        else       load_half_s = 1'b0;
      end
      S_START: begin
        if (cnt_zero_s) begin
          if (!rx_s) begin
            load_bit_s = 1'b1;
            clr_idx_s  = 1'b1;
          end else begin
            load_bit_s = 1'b0;
          end
        end else begin
          dec_s = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_zero_s) begin
          shift_en_s = 1'b1;
          load_bit_s = 1'b1;
        end else begin
          dec_s = 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_zero_s) begin
          if (rx_s) byte_done_s = 1'b1;
          else      frame_err_s = 1'b1;
        end else begin
          dec_s = 1'b1;
        end
      end
      S_BREAK: begin
        dec_s = 1'b0;
      end
      default: begin
        dec_s = 1'b0;
      end
    endcase
  end

  // Baud counter, bit index and shift register
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    if (load_half_s)     cnt_d = HALF_LOAD;
    else if (load_bit_s) cnt_d = BIT_LOAD;
    else if (dec_s)      cnt_d = cnt_q - CNT_ONE;
    else                 cnt_d = cnt_q;

    if (clr_idx_s)       bit_idx_d = 3'd0;
    else if (shift_en_s) bit_idx_d = bit_idx_q + 3'd1;
    else                 bit_idx_d = bit_idx_q;

    if (shift_en_s) shift_d = {rx_s, shift_q[7:1]};
    else            shift_d = shift_q;
  end

  // Holding register: a consuming ack frees the slot in the same cycle a new byte lands,
  // and ack_wait keeps the next byte hidden until the consumer releases ack.
  always_comb begin
    data_d     = data_q;
    pending_d  = pending_q;
    overrun_d  = overrun_q;
    ack_wait_d = ack_wait_q;

    if (consume_s) pending_d = 1'b0;
    else           pending_d = pending_q;

    if (byte_done_s) begin
      if (!pending_q || consume_s) begin
        data_d    = shift_q;
        pending_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = overrun_q;
    end

    if (consume_s)                  ack_wait_d = 1'b1;
    else if (!rx_if.UART_RX_ack)    ack_wait_d = 1'b0;
    else                            ack_wait_d = ack_wait_q;

    valid_d     = pending_d & ~ack_wait_d;
    frame_err_d = frame_err_s;
    busy_d      = (state_d != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q      <= 2'b11;
      cnt_q       <= {CNT_W{1'b0}};
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      pending_q   <= 1'b0;
      ack_wait_q  <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], RX_SERIAL};
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      pending_q   <= pending_d;
      ack_wait_q  <= ack_wait_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_if.UART_RX       = data_q;
  assign rx_if.UART_RX_valid = valid_q;
  assign FRAME_ERR           = frame_err_q;
  assign OVERRUN             = overrun_q;
  assign RX_BUSY             = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 10 clocks per bit: a byte table for the
// normal receive/ack path plus hand-written frame-error, glitch, overrun and reset cases.
module tb_uart_rx_byte;
  localparam int CLK_FREQ = 1000000;
  localparam int BAUD     = 100000;
  localparam int CPB      = 10;

  logic CLK = 1'b0;
  logic RESET;
  logic RX_SERIAL;
  logic FRAME_ERR, OVERRUN, RX_BUSY;

  uart_rx_byte_if bus ();

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RX_SERIAL (RX_SERIAL),
    .rx_if     (bus),
    .FRAME_ERR (FRAME_ERR),
    .OVERRUN   (OVERRUN),
    .RX_BUSY   (RX_BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Negedge monitor: valid rising edges, frame-error cycles, data stability while valid.
  int         cyc = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         fe_cycles = 0;
  int         stab_err = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] rise_data = 8'h00;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (bus.UART_RX_valid === 1'b1 && !prev_valid) begin
      rise_cnt  = rise_cnt + 1;
      rise_cyc  = cyc;
      rise_data = bus.UART_RX;
    end
    if (bus.UART_RX_valid === 1'b1 && prev_valid && bus.UART_RX !== prev_data)
      stab_err = stab_err + 1;
    if (FRAME_ERR === 1'b1) fe_cycles = fe_cycles + 1;
    prev_valid = (bus.UART_RX_valid === 1'b1);
    prev_data  = bus.UART_RX;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int start_cyc;

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      RX_SERIAL = f[i];
      tick(CPB);
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (bus.UART_RX_valid !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, bus.UART_RX_valid}, 32'd1);
  endtask

  // Ack after dly cycles, hold it two cycles, release.
  task automatic consume(input string name, input int dly);
    tick(dly);
    bus.UART_RX_ack = 1'b1;
    tick(1);
    check({name, "_drop"}, {31'd0, bus.UART_RX_valid}, 32'd0);
    tick(1);
    bus.UART_RX_ack = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] exp;
    int         ack_dly;
  } vec_t;

  vec_t vecs[9];
  int   r0, f0, n;
  logic seen;

  initial begin
    vecs[0] = '{8'h73, 8'h73, 0};
    vecs[1] = '{8'h00, 8'h00, 1};
    vecs[2] = '{8'h00, 8'h00, 2};
    vecs[3] = '{8'h00, 8'h00, 0};
    vecs[4] = '{8'h09, 8'h09, 1};
    vecs[5] = '{8'h00, 8'h00, 2};
    vecs[6] = '{8'h00, 8'h00, 1};
    vecs[7] = '{8'h00, 8'h00, 0};
    vecs[8] = '{8'h05, 8'h05, 2};

    RESET = 1'b1;
    RX_SERIAL = 1'b1;
    bus.UART_RX_ack = 1'b0;
    tick(3);
    check("rst_data",    {24'd0, bus.UART_RX},       32'h00);
    check("rst_valid",   {31'd0, bus.UART_RX_valid}, 32'd0);
    check("rst_ferr",    {31'd0, FRAME_ERR},         32'd0);
    check("rst_overrun", {31'd0, OVERRUN},           32'd0);
    check("rst_busy",    {31'd0, RX_BUSY},           32'd0);
    RESET = 1'b0;
    tick(10);

    // Single byte, ack held low: latency and hold
    r0 = rise_cnt;
    send_frame(8'h73, 1'b1);
    wait_valid("s1_valid");
    check("s1_data", {24'd0, bus.UART_RX}, 32'h73);
    check("s1_latency", {31'd0, (rise_cyc - start_cyc >= 96) && (rise_cyc - start_cyc <= 101)}, 32'd1);
    tick(20);
    check("s1_hold_valid", {31'd0, bus.UART_RX_valid}, 32'd1);
    check("s1_hold_data", {24'd0, bus.UART_RX}, 32'h73);
    check("s1_ferr", fe_cycles, 32'd0);
    check("s1_overrun", {31'd0, OVERRUN}, 32'd0);
    consume("s1", 0);
    tick(5);

    // 9-byte packet from the vector table
    for (int i = 0; i < 9; i++) begin
      r0 = rise_cnt;
      send_frame(vecs[i].tx, 1'b1);
      wait_valid($sformatf("pkt%0d_valid", i));
      check($sformatf("pkt%0d_data", i), {24'd0, bus.UART_RX}, {24'd0, vecs[i].exp});
      check($sformatf("pkt%0d_rises", i), rise_cnt - r0, 32'd1);
      consume($sformatf("pkt%0d", i), vecs[i].ack_dly);
      check($sformatf("pkt%0d_overrun", i), {31'd0, OVERRUN}, 32'd0);
    end
    check("pkt_ferr", fe_cycles, 32'd0);
    tick(5);

    // Framing error then long break, followed by a clean byte
    r0 = rise_cnt;
    f0 = fe_cycles;
    send_frame(8'h41, 1'b0);
    tick(30);
    RX_SERIAL = 1'b1;
    tick(20);
    check("fe_pulse", fe_cycles - f0, 32'd1);
    check("fe_no_valid", rise_cnt - r0, 32'd0);
    check("fe_busy_idle", {31'd0, RX_BUSY}, 32'd0);
    send_frame(8'h42, 1'b1);
    wait_valid("fe_next_valid");
    check("fe_next_data", {24'd0, bus.UART_RX}, 32'h42);
    consume("fe_next", 1);
    tick(5);

    // Three-cycle glitch on an idle line
    r0 = rise_cnt;
    f0 = fe_cycles;
    RX_SERIAL = 1'b0;
    tick(3);
    check("gl_busy_seen", {31'd0, RX_BUSY}, 32'd1);
    RX_SERIAL = 1'b1;
    n = 0;
    while (RX_BUSY === 1'b1 && n < 10) begin
      tick(1);
      n++;
    end
    check("gl_busy_low", {31'd0, (n <= 6) && (RX_BUSY === 1'b0)}, 32'd1);
    tick(20);
    check("gl_no_valid", rise_cnt - r0, 32'd0);
    check("gl_no_ferr", fe_cycles - f0, 32'd0);

    // Ack held high across the completion of the next byte
    send_frame(8'h33, 1'b1);
    wait_valid("ha_first_valid");
    check("ha_first_data", {24'd0, bus.UART_RX}, 32'h33);
    bus.UART_RX_ack = 1'b1;
    tick(1);
    check("ha_first_drop", {31'd0, bus.UART_RX_valid}, 32'd0);
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b1);
    tick(5);
    check("ha_hidden", {31'd0, bus.UART_RX_valid}, 32'd0);
    check("ha_no_rise", rise_cnt - r0, 32'd0);
    check("ha_overrun", {31'd0, OVERRUN}, 32'd0);
    bus.UART_RX_ack = 1'b0;
    tick(1);
    check("ha_valid", {31'd0, bus.UART_RX_valid}, 32'd1);
    check("ha_data", {24'd0, bus.UART_RX}, 32'hA5);
    consume("ha", 1);
    tick(5);

    // Two bytes back to back, no ack: second is dropped
    r0 = rise_cnt;
    send_frame(8'h11, 1'b1);
    check("ov_before", {31'd0, OVERRUN}, 32'd0);
    send_frame(8'h22, 1'b1);
    tick(2);
    check("ov_flag", {31'd0, OVERRUN}, 32'd1);
    check("ov_data", {24'd0, bus.UART_RX}, 32'h11);
    check("ov_valid", {31'd0, bus.UART_RX_valid}, 32'd1);
    consume("ov", 1);
    tick(30);
    check("ov_no_second", rise_cnt - r0, 32'd1);
    check("ov_valid_low", {31'd0, bus.UART_RX_valid}, 32'd0);
    check("ov_sticky", {31'd0, OVERRUN}, 32'd1);

    // Reset in the middle of a DATA phase
    r0 = rise_cnt;
    RX_SERIAL = 1'b0;
    tick(10);
    tick(10);
    RX_SERIAL = 1'b1;
    tick(5);
    check("rs_busy_before", {31'd0, RX_BUSY}, 32'd1);
    RESET = 1'b1;
    tick(2);
    check("rs_data",    {24'd0, bus.UART_RX},       32'h00);
    check("rs_valid",   {31'd0, bus.UART_RX_valid}, 32'd0);
    check("rs_ferr",    {31'd0, FRAME_ERR},         32'd0);
    check("rs_overrun", {31'd0, OVERRUN},           32'd0);
    check("rs_busy",    {31'd0, RX_BUSY},           32'd0);
    RESET = 1'b0;
    tick(120);
    check("rs_no_partial", rise_cnt - r0, 32'd0);
    check("rs_idle", {31'd0, RX_BUSY}, 32'd0);
    send_frame(8'h5A, 1'b1);
    wait_valid("rs_next_valid");
    check("rs_next_data", {24'd0, bus.UART_RX}, 32'h5A);
    seen = OVERRUN;
    check("rs_next_overrun", {31'd0, seen}, 32'd0);
    consume("rs_next", 2);

    check("data_stable", stab_err, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
